// File: rtl/fprint_port_arbiter_pkg.sv
// Shared widths, register-command opcodes and arbiter FSM states for the
// fingerprint register-file port arbiter.
package fprint_port_arbiter_pkg;

    localparam int FP_CRC_WIDTH = 32;
    localparam int FP_KEY_WIDTH = 4;

    typedef enum logic [2:0] {
        OP_IDLE        = 3'd0,
        OP_WR_CORE0    = 3'd1,
        OP_WR_CORE1    = 3'd2,
        OP_VERIFY      = 3'd3,
        OP_RESET_READY = 3'd4,
        OP_RESET_TASK  = 3'd5,
        OP_STATUS_WR   = 3'd6
    } reg_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ACK   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/fprint_port_arbiter_if.sv
// Command bus from the arbiter into the fingerprint register file.
interface fprint_port_arbiter_if
    import fprint_port_arbiter_pkg::*;
#(
    parameter int CRC_WIDTH = FP_CRC_WIDTH,
    parameter int KEY_WIDTH = FP_KEY_WIDTH
);
    logic                 reg_cmd_valid;
    logic [2:0]           reg_cmd_op;
    logic [KEY_WIDTH-1:0] reg_cmd_task;
    logic [CRC_WIDTH-1:0] reg_cmd_data;

    modport master (
        output reg_cmd_valid,
        output reg_cmd_op,
        output reg_cmd_task,
        output reg_cmd_data
    );

    modport slave (
        input reg_cmd_valid,
        input reg_cmd_op,
        input reg_cmd_task,
        input reg_cmd_data
    );
endinterface

// File: rtl/fprint_rr2.sv
// Two-way round-robin core picker with per-core saturating starvation counters;
// a starved requesting core is preferred over a non-starved one.
module fprint_rr2 #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       arb,
    input  logic       grant_vld,
    input  logic       grant_idx,
    output logic       chosen,
    output logic [1:0] starved
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt [2];
    logic             rr_last;
    logic [1:0]       cand;

    assign starved = {cnt[1] == LIMIT, cnt[0] == LIMIT};

    always_comb begin
        cand   = (|(starved & req)) ? (starved & req) : req;
        chosen = (cand == 2'b11) ? ~rr_last : cand[1];
    end

    // Counters only move in an arbitration round; a loser that is requesting ages.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt[0]  <= '0;
            cnt[1]  <= '0;
            rr_last <= 1'b1;
        end else if (arb) begin
            for (int i = 0; i < 2; i++) begin
                if (grant_vld && (grant_idx == i[0]))
                    cnt[i] <= '0;
                else if (req[i] && (cnt[i] != LIMIT))
                    cnt[i] <= cnt[i] + 1'b1;
            end
            if (grant_vld)
                rr_last <= grant_idx;
        end
    end
endmodule

// File: rtl/fprint_port_arbiter.sv
// Serialises core fingerprint writes and comparator requests onto the single
// register-file command port: IDLE -> ISSUE (command strobe) -> ACK (requester ack).
module fprint_port_arbiter
    import fprint_port_arbiter_pkg::*;
#(
    parameter int CRC_WIDTH    = FP_CRC_WIDTH,
    parameter int KEY_WIDTH    = FP_KEY_WIDTH,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 core0_req,
    input  logic [KEY_WIDTH-1:0] core0_task,
    input  logic [CRC_WIDTH-1:0] core0_crc,
    output logic                 core0_ack,
    input  logic                 core1_req,
    input  logic [KEY_WIDTH-1:0] core1_task,
    input  logic [CRC_WIDTH-1:0] core1_crc,
    output logic                 core1_ack,
    input  logic [KEY_WIDTH-1:0] comp_task,
    input  logic                 comp_mismatch,
    input  logic                 comp_task_verified,
    input  logic                 comp_reset_fprint_ready,
    input  logic                 comp_reset_task,
    input  logic                 comp_status_write,
    output logic                 fprint_reg_ack,
    output logic                 reset_fprint_ack,
    output logic                 reset_task_ack,
    output logic                 comp_status_ack,
    fprint_port_arbiter_if.master reg_cmd,
    output logic                 busy
);
    arb_state_e           state;
    logic [1:0]           core_req;
    logic                 comp_any;
    logic                 arb;
    logic                 core_chosen;
    logic [1:0]           starved;
    logic                 core_win;
    reg_op_e              win_op;
    logic [KEY_WIDTH-1:0] win_task;
    logic [CRC_WIDTH-1:0] win_data;

    assign core_req = {core1_req, core0_req};
    assign comp_any = comp_task_verified | comp_reset_fprint_ready |
                      comp_reset_task | comp_status_write;
    assign arb      = (state == ST_IDLE) && ((|core_req) || comp_any);

    fprint_rr2 #(.STARVE_LIMIT(STARVE_LIMIT)) u_rr2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (core_req),
        .arb       (arb),
        .grant_vld (core_win),
        .grant_idx (core_chosen),
        .chosen    (core_chosen),
        .starved   (starved)
    );

    // Starved core first, then the comparator (fixed internal priority), then cores.
    always_comb begin
        core_win = 1'b0;
        win_op   = OP_IDLE;
        win_task = '0;
        win_data = '0;
        if ((|(starved & core_req)) || (!comp_any && (|core_req))) begin
            core_win = 1'b1;
            win_op   = core_chosen ? OP_WR_CORE1 : OP_WR_CORE0;
            win_task = core_chosen ? core1_task : core0_task;
            win_data = core_chosen ? core1_crc : core0_crc;
        end else if (comp_task_verified) begin
            win_op   = OP_VERIFY;
            win_task = comp_task;
        end else if (comp_reset_fprint_ready) begin
            win_op   = OP_RESET_READY;
            win_task = comp_task;
        end else if (comp_reset_task) begin
            win_op   = OP_RESET_TASK;
            win_task = comp_task;
        end else if (comp_status_write) begin
            win_op   = OP_STATUS_WR;
            win_task = comp_task;
            win_data = {{(CRC_WIDTH-1){1'b0}}, comp_mismatch};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                 <= ST_IDLE;
            busy                  <= 1'b0;
            reg_cmd.reg_cmd_valid <= 1'b0;
            reg_cmd.reg_cmd_op    <= OP_IDLE;
            reg_cmd.reg_cmd_task  <= '0;
            reg_cmd.reg_cmd_data  <= '0;
            core0_ack             <= 1'b0;
            core1_ack             <= 1'b0;
            fprint_reg_ack        <= 1'b0;
            reset_fprint_ack      <= 1'b0;
            reset_task_ack        <= 1'b0;
            comp_status_ack       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb) begin
                        state                 <= ST_ISSUE;
                        busy                  <= 1'b1;
                        reg_cmd.reg_cmd_valid <= 1'b1;
                        reg_cmd.reg_cmd_op    <= win_op;
                        reg_cmd.reg_cmd_task  <= win_task;
                        reg_cmd.reg_cmd_data  <= win_data;
                    end
                end
                ST_ISSUE: begin
                    // The opcode still held on the bus names the requester to ack.
                    state                 <= ST_ACK;
                    reg_cmd.reg_cmd_valid <= 1'b0;
                    reg_cmd.reg_cmd_op    <= OP_IDLE;
                    reg_cmd.reg_cmd_task  <= '0;
                    reg_cmd.reg_cmd_data  <= '0;
                    core0_ack             <= (reg_cmd.reg_cmd_op == OP_WR_CORE0);
                    core1_ack             <= (reg_cmd.reg_cmd_op == OP_WR_CORE1);
                    fprint_reg_ack        <= (reg_cmd.reg_cmd_op == OP_VERIFY);
                    reset_fprint_ack      <= (reg_cmd.reg_cmd_op == OP_RESET_READY);
                    reset_task_ack        <= (reg_cmd.reg_cmd_op == OP_RESET_TASK);
                    comp_status_ack       <= (reg_cmd.reg_cmd_op == OP_STATUS_WR);
                end
                ST_ACK: begin
                    state            <= ST_IDLE;
                    busy             <= 1'b0;
                    core0_ack        <= 1'b0;
                    core1_ack        <= 1'b0;
                    fprint_reg_ack   <= 1'b0;
                    reset_fprint_ack <= 1'b0;
                    reset_task_ack   <= 1'b0;
                    comp_status_ack  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fprint_port_arbiter.sv
// Scoreboard bench: a transaction-level model predicts every served command and
// its ack; a negedge monitor compares the DUT's bus and ack pulses against it.
module tb_fprint_port_arbiter;
    import fprint_port_arbiter_pkg::*;

    localparam int CW  = 32;
    localparam int KW  = 4;
    localparam int LIM = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          core0_req = 1'b0, core1_req = 1'b0;
    logic [KW-1:0] core0_task = '0, core1_task = '0, comp_task = '0;
    logic [CW-1:0] core0_crc = '0, core1_crc = '0;
    logic          comp_mismatch = 1'b0;
    logic [3:0]    comp_bits = '0;
    logic          core0_ack, core1_ack, fprint_reg_ack, reset_fprint_ack;
    logic          reset_task_ack, comp_status_ack, busy;
    logic          comp_task_verified, comp_reset_fprint_ready, comp_reset_task, comp_status_write;

    assign comp_task_verified      = comp_bits[3];
    assign comp_reset_fprint_ready = comp_bits[2];
    assign comp_reset_task         = comp_bits[1];
    assign comp_status_write       = comp_bits[0];

    always #5 clk = ~clk;

    fprint_port_arbiter_if #(.CRC_WIDTH(CW), .KEY_WIDTH(KW)) cmd_if ();

    fprint_port_arbiter #(.CRC_WIDTH(CW), .KEY_WIDTH(KW), .STARVE_LIMIT(LIM)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .core0_req               (core0_req),
        .core0_task              (core0_task),
        .core0_crc               (core0_crc),
        .core0_ack               (core0_ack),
        .core1_req               (core1_req),
        .core1_task              (core1_task),
        .core1_crc               (core1_crc),
        .core1_ack               (core1_ack),
        .comp_task               (comp_task),
        .comp_mismatch           (comp_mismatch),
        .comp_task_verified      (comp_task_verified),
        .comp_reset_fprint_ready (comp_reset_fprint_ready),
        .comp_reset_task         (comp_reset_task),
        .comp_status_write       (comp_status_write),
        .fprint_reg_ack          (fprint_reg_ack),
        .reset_fprint_ack        (reset_fprint_ack),
        .reset_task_ack          (reset_task_ack),
        .comp_status_ack         (comp_status_ack),
        .reg_cmd                 (cmd_if),
        .busy                    (busy)
    );

    typedef struct {
        int            e;
        logic [2:0]    op;
        logic [KW-1:0] tid;
        logic [CW-1:0] data;
    } txn_t;

    txn_t exp_q[$];
    txn_t obs_q[$];
    int   cyc = 0;
    int   n_vec = 0, n_err = 0;
    int   free_at = 0, rr_last = 1;
    int   starve [2] = '{0, 0};
    int   p_core [2] = '{0, 0};
    int   p_comp = 0;
    logic [3:0] comp_fixed = '0;
    bit   comp_multi = 1'b0;
    bit   kill_c1 = 1'b0, killed = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every negedge, compare strobe/acks/busy and pop the served transaction.
    always @(negedge clk) begin
        logic [7:0] outv, ev;
        outv = {cmd_if.reg_cmd_valid, core0_ack, core1_ack, fprint_reg_ack,
                reset_fprint_ack, reset_task_ack, comp_status_ack, busy};
        if (!reset_n) begin
            chk("reset_ctl", 64'(outv), 64'd0);
            chk("reset_bus", 64'({cmd_if.reg_cmd_op, cmd_if.reg_cmd_task, cmd_if.reg_cmd_data}), 64'd0);
        end else begin
            ev = 8'h00;
            if (exp_q.size() > 0) begin
                if (cyc == exp_q[0].e)
                    ev = 8'h81;
                else if (cyc == exp_q[0].e + 1)
                    ev = 8'h01 | (8'h01 << (7 - int'(exp_q[0].op)));
            end
            chk("ctl", 64'(outv), 64'(ev));
            if (cmd_if.reg_cmd_valid) begin
                obs_q.push_back('{cyc, cmd_if.reg_cmd_op, cmd_if.reg_cmd_task, cmd_if.reg_cmd_data});
                if (exp_q.size() > 0 && cyc == exp_q[0].e) begin
                    chk("op", 64'(cmd_if.reg_cmd_op), 64'(exp_q[0].op));
                    chk("task", 64'(cmd_if.reg_cmd_task), 64'(exp_q[0].tid));
                    chk("data", 64'(cmd_if.reg_cmd_data), 64'(exp_q[0].data));
                end
            end
            if (exp_q.size() > 0 && cyc >= exp_q[0].e + 1)
                void'(exp_q.pop_front());
        end
    end

    task automatic model_reset();
        free_at = 0;
        rr_last = 1;
        starve  = '{0, 0};
        exp_q.delete();
    endtask

    // Reference: predict the arbitration decision taken at the next rising edge.
    task automatic model();
        int e, w;
        bit [1:0] r;
        bit st0, st1;
        logic [2:0] op;
        logic [KW-1:0] tid;
        logic [CW-1:0] data;
        if (!reset_n) return;
        e = cyc + 1;
        r = {core1_req, core0_req};
        if (e < free_at || (r == 2'b00 && comp_bits == 4'b0000)) return;
        st0 = r[0] && (starve[0] == LIM);
        st1 = r[1] && (starve[1] == LIM);
        w = -1;
        op = 3'd0;
        if (st0 || st1)
            w = (st0 && st1) ? 1 - rr_last : (st0 ? 0 : 1);
        else if (comp_bits != 4'b0000)
            op = comp_bits[3] ? 3'd3 : comp_bits[2] ? 3'd4 : comp_bits[1] ? 3'd5 : 3'd6;
        else
            w = (r == 2'b11) ? 1 - rr_last : (r[0] ? 0 : 1);
        if (w >= 0) begin
            op   = 3'(w + 1);
            tid  = (w == 1) ? core1_task : core0_task;
            data = (w == 1) ? core1_crc : core0_crc;
            rr_last = w;
        end else begin
            tid  = comp_task;
            data = (op == 3'd6) ? CW'(comp_mismatch) : '0;
        end
        for (int i = 0; i < 2; i++) begin
            if (w == i) starve[i] = 0;
            else if (r[i] && starve[i] < LIM) starve[i]++;
        end
        exp_q.push_back('{e, op, tid, data});
        free_at = e + 3;
    endtask

    // Requesters: hold until ack, drop on the ack, maybe re-raise next cycle.
    task automatic drive();
        if (core0_ack) core0_req = 1'b0;
        else if (!core0_req && $urandom_range(99) < p_core[0]) begin
            core0_req = 1'b1; core0_task = KW'($urandom); core0_crc = $urandom;
        end
        if (core1_ack) core1_req = 1'b0;
        else if (!core1_req && $urandom_range(99) < p_core[1]) begin
            core1_req = 1'b1; core1_task = KW'($urandom); core1_crc = $urandom;
        end
        if (fprint_reg_ack || reset_fprint_ack || reset_task_ack || comp_status_ack) begin
            if (fprint_reg_ack)   comp_bits[3] = 1'b0;
            if (reset_fprint_ack) comp_bits[2] = 1'b0;
            if (reset_task_ack)   comp_bits[1] = 1'b0;
            if (comp_status_ack)  comp_bits[0] = 1'b0;
        end else if (comp_bits == 4'b0000 && $urandom_range(99) < p_comp) begin
            if (comp_fixed != 4'b0000) comp_bits = comp_fixed;
            else if (comp_multi)       comp_bits = 4'($urandom_range(15, 1));
            else                       comp_bits = 4'b0001 << $urandom_range(3);
            comp_task = KW'($urandom);
            comp_mismatch = 1'($urandom);
        end
    endtask

    task automatic tick_pre();
        @(negedge clk);
        #2;
    endtask

    task automatic tick_post();
        if (kill_c1 && cmd_if.reg_cmd_valid && cmd_if.reg_cmd_op == 3'd2) begin
            reset_n = 1'b0;
            model_reset();
            kill_c1 = 1'b0;
            killed  = 1'b1;
        end
        drive();
        model();
    endtask

    task automatic tick();
        tick_pre();
        tick_post();
    endtask

    task automatic do_reset(input int n);
        tick_pre();
        reset_n = 1'b0;
        core0_req = 1'b0; core1_req = 1'b0; comp_bits = 4'b0000;
        model_reset();
        tick_post();
        repeat (n) tick();
        tick_pre();
        reset_n = 1'b1;
        tick_post();
        obs_q.delete();
    endtask

    function automatic logic [2:0] obs_op(input int i);
        return (obs_q.size() > i) ? obs_q[i].op : 3'd7;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
        $fatal(1);
    end

    initial begin
        do_reset(3);

        // Single core0 write with fixed payload.
        tick_pre();
        core0_req = 1'b1; core0_task = 4'd3; core0_crc = 32'hDEADBEEF;
        tick_post();
        repeat (6) tick();
        chk("s1_count", 64'(obs_q.size()), 64'd1);
        chk("s1_op", 64'(obs_op(0)), 64'd1);
        chk("s1_task", 64'(obs_q.size() > 0 ? obs_q[0].tid : '1), 64'd3);
        chk("s1_data", 64'(obs_q.size() > 0 ? obs_q[0].data : '0), 64'hDEADBEEF);

        // Both cores held: strict alternation starting at core0.
        p_core = '{100, 100};
        do_reset(2);
        repeat (14) tick();
        for (int i = 0; i < 4; i++) chk("alt_op", 64'(obs_op(i)), 64'((i % 2) + 1));
        if (obs_q.size() >= 2) chk("alt_gap", 64'(obs_q[1].e - obs_q[0].e), 64'd3);

        // Status write carries the mismatch flag as data.
        p_core = '{0, 0};
        do_reset(2);
        tick_pre();
        comp_bits = 4'b0001; comp_task = 4'd7; comp_mismatch = 1'b1;
        tick_post();
        repeat (6) tick();
        chk("st_op", 64'(obs_op(0)), 64'd6);
        chk("st_task", 64'(obs_q.size() > 0 ? obs_q[0].tid : '0), 64'd7);
        chk("st_data", 64'(obs_q.size() > 0 ? obs_q[0].data : '0), 64'd1);

        // Comparator hogging: core1 wins on the ninth round.
        p_core = '{0, 100}; p_comp = 100; comp_fixed = 4'b1000;
        do_reset(2);
        repeat (32) tick();
        for (int i = 0; i < 8; i++) chk("starve_comp", 64'(obs_op(i)), 64'd3);
        chk("starve_core1", 64'(obs_op(8)), 64'd2);
        chk("starve_after", 64'(obs_op(9)), 64'd3);

        // Two comparator requests at once: reset_ready before reset_task.
        p_core = '{0, 0}; p_comp = 0; comp_fixed = 4'b0000;
        do_reset(2);
        tick_pre();
        comp_bits = 4'b0110; comp_task = 4'd9;
        tick_post();
        repeat (8) tick();
        chk("pri_first", 64'(obs_op(0)), 64'd4);
        chk("pri_second", 64'(obs_op(1)), 64'd5);

        // Reset during a core1 ISSUE: no ack, then core0 preferred.
        p_core = '{0, 100};
        do_reset(2);
        kill_c1 = 1'b1;
        killed  = 1'b0;
        for (int i = 0; i < 20 && !killed; i++) tick();
        chk("kill_reached", 64'(killed), 64'd1);
        kill_c1 = 1'b0;
        repeat (3) tick();
        tick_pre();
        reset_n = 1'b1;
        p_core = '{100, 100};
        obs_q.delete();
        tick_post();
        repeat (8) tick();
        chk("post_reset_first", 64'(obs_op(0)), 64'd1);

        // Randomised traffic with varying request densities.
        for (int c = 0; c < 20; c++) begin
            p_core[0]  = $urandom_range(100);
            p_core[1]  = $urandom_range(100);
            p_comp     = $urandom_range(100);
            comp_multi = 1'($urandom);
            repeat (150) tick();
        end
        p_core = '{0, 0}; p_comp = 0;
        repeat (40) tick();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
